prog_loader: RTL and testbench
==============================

# prog_loader

Byte-stream program loader that writes instruction words into the single-cycle CPU's instruction memory, which the CPU then fetches and decodes opcodes from. It parses a framed stream (sync, length, 16-bit words, XOR checksum), drives the memory write port, and holds the CPU in reset until a valid image has been loaded. It sits between the serial/I/O receive path and the instruction memory write port.

## Interface
- WORD_W, 16, instruction word width; opcode occupies bits [15:10]
- ADDR_W, 10, instruction memory address width (depth 2^ADDR_W)
- SYNC, 8'hA5, frame start byte
- clk  in  1  rising-edge clock
- reset  in  1  asynchronous, active-high reset
- rx_data  in  8  incoming byte
- rx_valid  in  1  rx_data valid
- rx_ready  out  1  loader accepts byte; a transfer occurs when rx_valid && rx_ready at a rising edge
- mem_we  out  1  instruction memory write enable, one-cycle pulse per word
- mem_addr  out  ADDR_W  write address
- mem_wdata  out  WORD_W  write data
- cpu_hold  out  1  holds CPU in reset while high
- done  out  1  last frame loaded and checksum matched
- error  out  1  last frame rejected

## Operation
- States: IDLE, LEN_HI, LEN_LO, DATA_HI, DATA_LO, CHECK, DONE, ERR.
- IDLE: non-SYNC bytes discarded; SYNC -> LEN_HI, clear checksum, word counter and address.
- LEN_HI/LEN_LO: 16-bit word count N, big-endian; both bytes fold into checksum.
- After LEN_LO: N == 0 -> CHECK; N > 2^ADDR_W -> ERR; else DATA_HI.
- DATA_HI/DATA_LO: word big-endian; each byte folds into checksum (XOR). On DATA_LO acceptance, register word, pulse mem_we next cycle at current address, then address +1. After Nth word -> CHECK, else DATA_HI.
- SYNC value inside length/data/checksum is plain data; no resync mid-frame.
- CHECK: received byte == accumulated XOR -> DONE, else ERR.
- DONE: done=1, error=0, cpu_hold=0. SYNC -> LEN_HI, done=0, cpu_hold=1; other bytes discarded.
- ERR: error=1, done=0, cpu_hold=1. SYNC -> LEN_HI, error=0; other bytes discarded.
- Words already written before an ERR remain in memory; cpu_hold keeps CPU off them.
- rx_ready is 1 in every state after reset; loader never back-pressures.

## Timing
- Reset values: state IDLE, rx_ready=0, mem_we=0, mem_addr=0, mem_wdata=0, cpu_hold=1, done=0, error=0; rx_ready rises first clock after reset deasserts.
- Accepts one byte per cycle, back-to-back.
- mem_we/mem_addr/mem_wdata valid together, one cycle after DATA_LO byte accepted; mem_addr advances the following cycle.
- done/error and cpu_hold update the cycle after the checksum byte is accepted.
- Full-depth frame (N = 2^ADDR_W): last write at address 2^ADDR_W-1; address wraps to 0 without extra write.
- Reset mid-frame: immediate return to reset values; pending write dropped.

## Structure
- Shared package: state enum, SYNC default, frame byte order constants.
- Single module; checksum accumulator and word counter inline. No sub-module needed.

## Test plan
- A5 00 02 12 34 56 78 (12^34^56^78^00^02=0x0A) 0A -> writes 0x1234@0, 0x5678@1; done=1, cpu_hold=0.
- Same frame, checksum 0x0B -> two writes occur, then error=1, cpu_hold=1, done=0.
- A5 00 00 00 -> no writes, done=1; then A5 04 01 -> error=1 (N=1025 > 1024).
- Garbage 00 FF 5A then valid frame -> garbage ignored, frame loads at address 0.
- Data word 0xA5A5 inside frame -> written as data, no resync.
- Reset asserted after first DATA_HI -> no mem_we, outputs at reset values; new frame loads cleanly.

Source files
------------

// File: rtl/prog_loader_pkg.sv
// prog_loader shared definitions: widths, sync byte,
// frame byte order and the loader state encoding.
package prog_loader_pkg;

  localparam int unsigned PL_WORD_W = 16;
  localparam int unsigned PL_ADDR_W = 10;
  localparam logic [7:0]  PL_SYNC   = 8'hA5;

  // Length and data words arrive most significant byte first.
  localparam bit PL_BIG_ENDIAN = 1'b1;

  typedef enum logic [2:0] {
    S_IDLE,
    S_LEN_HI,
    S_LEN_LO,
    S_DATA_HI,
    S_DATA_LO,
    S_CHECK,
    S_DONE,
    S_ERR
  } state_t;

  function automatic logic [15:0] join_bytes(
    input logic [7:0] first,
    input logic [7:0] second
  );
    return PL_BIG_ENDIAN ? {first, second}
                         : {second, first};
  endfunction

endpackage

// File: rtl/prog_loader_if.sv
// prog_loader bus: byte receive stream, imem write port, status.
// master = loader side, slave = byte source / memory / CPU side.
interface prog_loader_if
  import prog_loader_pkg::*;
#(
  parameter int unsigned WORD_W = PL_WORD_W,
  parameter int unsigned ADDR_W = PL_ADDR_W
);

  logic [7:0]        rx_data;
  logic              rx_valid;
  logic              rx_ready;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [WORD_W-1:0] mem_wdata;
  logic              cpu_hold;
  logic              done;
  logic              error;

  modport master (
    input  rx_data, rx_valid,
    output rx_ready,
    output mem_we, mem_addr, mem_wdata,
    output cpu_hold, done, error
  );

  modport slave (
    output rx_data, rx_valid,
    input  rx_ready,
    input  mem_we, mem_addr, mem_wdata,
    input  cpu_hold, done, error
  );

endinterface

// File: rtl/prog_loader.sv
// Framed byte-stream loader: SYNC, 16-bit count, words, XOR sum.
// Ports: clk, reset (async, active-high), bus (prog_loader_if.master).
module prog_loader
  import prog_loader_pkg::*;
#(
  parameter int unsigned WORD_W = PL_WORD_W,
  parameter int unsigned ADDR_W = PL_ADDR_W,
  parameter logic [7:0]  SYNC   = PL_SYNC
) (
  input logic           clk,
  input logic           reset,
  prog_loader_if.master bus
);

  localparam logic [16:0] DEPTH = 17'(1) << ADDR_W;

  state_t            state_q, state_d;
  logic              rdy_q;
  logic [7:0]        hi_q, hi_d;
  logic [7:0]        csum_q, csum_d;
  logic [15:0]       len_q, len_d;
  logic [15:0]       cnt_q, cnt_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic              we_q, we_d;
  logic [WORD_W-1:0] wdata_q, wdata_d;

  logic              take;
  logic [7:0]        rx;
  logic [15:0]       pair;

  assign rx   = bus.rx_data;
  assign take = bus.rx_valid && rdy_q;
  assign pair = join_bytes(hi_q, rx);

  always_comb begin
    state_d = state_q;
    hi_d    = hi_q;
    csum_d  = csum_q;
    len_d   = len_q;
    cnt_d   = cnt_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    we_d    = 1'b0;

    // Address moves on only after the write pulse has been seen.
    if (we_q) addr_d = addr_q + ADDR_W'(1);

    if (take) begin
      unique case (state_q)
        S_IDLE, S_DONE, S_ERR: begin
          if (rx == SYNC) begin
            state_d = S_LEN_HI;
            csum_d  = '0;
            cnt_d   = '0;
            addr_d  = '0;
          end
        end
        S_LEN_HI: begin
          hi_d    = rx;
          csum_d  = csum_q ^ rx;
          state_d = S_LEN_LO;
        end
        S_LEN_LO: begin
          csum_d = csum_q ^ rx;
          len_d  = pair;
          if (pair == 16'd0)
            state_d = S_CHECK;
          else if ({1'b0, pair} > DEPTH)
            state_d = S_ERR;
          else
            state_d = S_DATA_HI;
        end
        S_DATA_HI: begin
          hi_d    = rx;
          csum_d  = csum_q ^ rx;
          state_d = S_DATA_LO;
        end
        S_DATA_LO: begin
          csum_d  = csum_q ^ rx;
          we_d    = 1'b1;
          wdata_d = WORD_W'(pair);
          cnt_d   = cnt_q + 16'd1;
          state_d = (cnt_d == len_q) ? S_CHECK
                                     : S_DATA_HI;
        end
        S_CHECK: begin
          state_d = (rx == csum_q) ? S_DONE : S_ERR;
        end
        default: state_d = S_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= S_IDLE;
      rdy_q   <= 1'b0;
      hi_q    <= '0;
      csum_q  <= '0;
      len_q   <= '0;
      cnt_q   <= '0;
      addr_q  <= '0;
      we_q    <= 1'b0;
      wdata_q <= '0;
    end else begin
      state_q <= state_d;
      rdy_q   <= 1'b1;
      hi_q    <= hi_d;
      csum_q  <= csum_d;
      len_q   <= len_d;
      cnt_q   <= cnt_d;
      addr_q  <= addr_d;
      we_q    <= we_d;
      wdata_q <= wdata_d;
    end
  end

  assign bus.rx_ready  = rdy_q;
  assign bus.mem_we    = we_q;
  assign bus.mem_addr  = addr_q;
  assign bus.mem_wdata = wdata_q;
  assign bus.done      = (state_q == S_DONE);
  assign bus.error     = (state_q == S_ERR);
  assign bus.cpu_hold  = (state_q != S_DONE);

endmodule

// File: tb/tb_prog_loader.sv
// tb_prog_loader: directed frame table, corner sequences and
// random frames checked against a frame-level model.
module tb_prog_loader;

  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  prog_loader_if bus ();

  prog_loader dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  int checks = 0;
  int failures = 0;

  logic [25:0] wr_q[$];

  always @(negedge clk)
    if (bus.mem_we === 1'b1)
      wr_q.push_back({bus.mem_addr, bus.mem_wdata});

  task automatic chk(input string nm,
                     input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h",
               nm, act, exp);
    end
  endtask

  task automatic send(input logic [7:0] b);
    @(negedge clk);
    bus.rx_data  = b;
    bus.rx_valid = 1'b1;
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(negedge clk);
      bus.rx_valid = 1'b0;
      bus.rx_data  = 8'($urandom);
    end
  endtask

  task automatic chk_status(input string nm,
                            input bit d,
                            input bit e);
    chk({nm, ".done"}, 32'(bus.done), 32'(d));
    chk({nm, ".error"}, 32'(bus.error), 32'(e));
    chk({nm, ".hold"}, 32'(bus.cpu_hold), 32'(!d));
  endtask

  task automatic chk_reset_vals(input string nm);
    chk(nm, {bus.rx_ready, bus.mem_we, bus.mem_addr,
             bus.mem_wdata, bus.cpu_hold, bus.done,
             bus.error},
        {1'b0, 1'b0, 10'd0, 16'd0, 1'b1, 1'b0, 1'b0});
  endtask

  typedef struct {
    logic [95:0] stim;
    int          n;
    int          nwr;
    logic [25:0] w0;
    logic [25:0] w1;
    bit          d;
    bit          e;
  } vec_t;

  vec_t vt[7];

  task automatic run_vec(input int k);
    wr_q.delete();
    for (int i = 0; i < vt[k].n; i++)
      send(vt[k].stim[95-8*i -: 8]);
    idle(3);
    chk($sformatf("v%0d.nwr", k),
        32'(wr_q.size()), 32'(vt[k].nwr));
    if (vt[k].nwr > 0 && wr_q.size() > 0)
      chk($sformatf("v%0d.w0", k), 32'(wr_q[0]),
          32'(vt[k].w0));
    if (vt[k].nwr > 1 && wr_q.size() > 1)
      chk($sformatf("v%0d.w1", k), 32'(wr_q[1]),
          32'(vt[k].w1));
    chk_status($sformatf("v%0d", k), vt[k].d, vt[k].e);
  endtask

  initial begin
    logic [7:0]  cs, b, h, l;
    logic [15:0] fw[1024];
    logic [25:0] exp_q[$];
    int          nbad, nw;
    bit          bad;

    vt[0] = '{{8'hA5, 8'h00, 8'h02, 8'h12, 8'h34, 8'h56,
               8'h78, 8'h0A, 32'h0}, 8, 2,
              {10'd0, 16'h1234}, {10'd1, 16'h5678}, 1, 0};
    vt[1] = '{{8'hA5, 8'h00, 8'h02, 8'h12, 8'h34, 8'h56,
               8'h78, 8'h0B, 32'h0}, 8, 2,
              {10'd0, 16'h1234}, {10'd1, 16'h5678}, 0, 1};
    vt[2] = '{{8'hA5, 8'h00, 8'h00, 8'h00, 64'h0}, 4, 0,
              26'h0, 26'h0, 1, 0};
    vt[3] = '{{8'hA5, 8'h04, 8'h01, 72'h0}, 3, 0,
              26'h0, 26'h0, 0, 1};
    vt[4] = '{{8'h00, 8'hFF, 8'h5A, 8'hA5, 8'h00, 8'h01,
               8'hAB, 8'hCD, 8'h67, 24'h0}, 9, 1,
              {10'd0, 16'hABCD}, 26'h0, 1, 0};
    vt[5] = '{{8'hA5, 8'h00, 8'h01, 8'hA5, 8'hA5, 8'h01,
               48'h0}, 6, 1,
              {10'd0, 16'hA5A5}, 26'h0, 1, 0};
    vt[6] = '{{8'h11, 8'h22, 8'hA5, 8'h00, 8'h01, 8'h00,
               8'h10, 8'h11, 32'h0}, 8, 1,
              {10'd0, 16'h0010}, 26'h0, 1, 0};

    bus.rx_data  = 8'h00;
    bus.rx_valid = 1'b0;

    // Reset values and rx_ready rising one clock after release.
    repeat (3) @(negedge clk);
    chk_reset_vals("reset_vals");
    reset = 1'b0;
    #1;
    chk("rdy_before_edge", 32'(bus.rx_ready), 32'd0);
    @(negedge clk);
    chk("rdy_after_edge", 32'(bus.rx_ready), 32'd1);

    for (int k = 0; k < 7; k++) run_vec(k);

    // Reset after the first data high byte.
    wr_q.delete();
    send(8'hA5); send(8'h00); send(8'h01); send(8'h12);
    @(negedge clk);
    bus.rx_valid = 1'b0;
    reset = 1'b1;
    #1;
    chk_reset_vals("midreset_vals");
    repeat (2) @(negedge clk);
    chk("midreset_nowr", 32'(wr_q.size()), 32'd0);
    reset = 1'b0;
    idle(2);
    run_vec(0);

    // Full-depth frame, then address wraps to 0 with no write.
    wr_q.delete();
    send(8'hA5); send(8'h04); send(8'h00);
    cs = 8'h04;
    for (int i = 0; i < 1024; i++) begin
      fw[i] = 16'($urandom);
      send(fw[i][15:8]);
      send(fw[i][7:0]);
      cs = cs ^ fw[i][15:8] ^ fw[i][7:0];
    end
    send(cs);
    idle(4);
    chk("full.nwr", 32'(wr_q.size()), 32'd1024);
    nbad = 0;
    for (int i = 0; i < wr_q.size() && i < 1024; i++)
      if (wr_q[i] !== {10'(i), fw[i]}) nbad++;
    chk("full.bad_writes", 32'(nbad), 32'd0);
    if (wr_q.size() > 0)
      chk("full.last_addr", 32'(wr_q[wr_q.size()-1][25:16]),
          32'd1023);
    chk("full.addr_wrap", 32'(bus.mem_addr), 32'd0);
    chk_status("full", 1, 0);

    // Random frames against a frame-level model.
    for (int f = 0; f < 30; f++) begin
      wr_q.delete();
      exp_q.delete();
      repeat ($urandom_range(0, 3)) begin
        b = 8'($urandom);
        if (b == 8'hA5) b = 8'h3C;
        send(b);
        idle($urandom_range(0, 2));
      end
      nw = $urandom_range(0, 6);
      bad = ($urandom_range(0, 3) == 0);
      send(8'hA5);
      idle($urandom_range(0, 2));
      send(8'h00);
      idle($urandom_range(0, 2));
      send(8'(nw));
      cs = 8'(nw);
      for (int i = 0; i < nw; i++) begin
        h = ($urandom_range(0, 3) == 0) ? 8'hA5
                                       : 8'($urandom);
        l = ($urandom_range(0, 3) == 0) ? 8'hA5
                                       : 8'($urandom);
        cs = cs ^ h ^ l;
        exp_q.push_back({10'(i), h, l});
        idle($urandom_range(0, 2));
        send(h);
        idle($urandom_range(0, 2));
        send(l);
      end
      if (bad) cs = cs ^ 8'($urandom_range(1, 255));
      idle($urandom_range(0, 2));
      send(cs);
      idle(3);
      chk($sformatf("rnd%0d.nwr", f),
          32'(wr_q.size()), 32'(exp_q.size()));
      nbad = 0;
      for (int i = 0; i < exp_q.size(); i++)
        if (i >= wr_q.size() || wr_q[i] !== exp_q[i])
          nbad++;
      chk($sformatf("rnd%0d.writes", f), 32'(nbad), 32'd0);
      chk_status($sformatf("rnd%0d", f), !bad, bad);
    end

    $display("TB_RESULT checks=%0d failures=%0d",
             checks, failures);
    $finish;
  end

endmodule
